// File: rtl/svm_feature_slice.sv
// ============================================================================
// Module   : svm_feature_slice
// Purpose  : Flow-controlled HOG-to-SVM register slice. It holds a DEPTH-entry
//            skid FIFO and tags each bundle with a slide-window index.
// Options  : SVM_SLICE_STATS_EN - enables the saturating backpressure counter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module svm_feature_slice #(
    parameter int FEA_I  = 4,
    parameter int FEA_F  = 28,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 2,
    parameter int SW_W   = 11,
    parameter int SW_NUM = 1200,
    localparam int BW    = NUM_CH * 9 * (FEA_I + FEA_F)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [BW-1:0]   s_fea,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [BW-1:0]   m_fea,
    output logic [SW_W-1:0] m_sw_id,
    output logic            m_last,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [4:0]      level,
    output logic [15:0]     stall_cnt
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [4:0]      LVL_FULL = 5'(DEPTH);
    localparam logic [SW_W-1:0] SW_LAST  = SW_W'(SW_NUM - 1);

    logic [BW-1:0]   fea_mem [DEPTH];
    logic [SW_W-1:0] id_mem  [DEPTH];

    logic [4:0]       level_q, level_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [SW_W-1:0]  wcnt_q, wcnt_d;

    logic push;
    logic pop;

    // Ready comes from registered occupancy only, so a full slice never
    // accepts input in the same cycle it pops.
    assign s_ready = (level_q < LVL_FULL);
    assign m_valid = (level_q != 5'd0);
    assign level   = level_q;

    assign push = s_valid && s_ready && !flush;
    assign pop  = m_valid && m_ready && !flush;

    always_comb begin
        level_d = level_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        wcnt_d  = wcnt_q;
        if (flush) begin
            level_d = 5'd0;
            wr_d    = '0;
            rd_d    = '0;
            wcnt_d  = '0;
        end else begin
            if (push) begin
                wr_d   = (wr_q == PTR_LAST) ? '0 : wr_q + PTR_W'(1);
                wcnt_d = (wcnt_q == SW_LAST) ? '0 : wcnt_q + SW_W'(1);
            end
            if (pop) begin
                rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + 5'd1;
                2'b01:   level_d = level_q - 5'd1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 5'd0;
            wr_q    <= '0;
            rd_q    <= '0;
            wcnt_q  <= '0;
        end else begin
            level_q <= level_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Payload storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fea_mem[wr_q] <= s_fea;
            id_mem[wr_q]  <= wcnt_q;
        end
    end

    // Outputs are forced to zero while empty so reset values are well defined.
    assign m_fea   = m_valid ? fea_mem[rd_q] : '0;
    assign m_sw_id = m_valid ? id_mem[rd_q]  : '0;
    assign m_last  = m_valid && (id_mem[rd_q] == SW_LAST);

`ifdef SVM_SLICE_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 16'h0000;
        end else if (m_valid && !m_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_svm_feature_slice.sv
// ============================================================================
// Module   : tb_svm_feature_slice
// Purpose  : Directed self-checking bench for svm_feature_slice (DEPTH=2,
//            SW_NUM=4, two channels of 8-bit bins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_svm_feature_slice;

    localparam int FEA_I  = 4;
    localparam int FEA_F  = 4;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 2;
    localparam int SW_W   = 11;
    localparam int SW_NUM = 4;
    localparam int BW     = NUM_CH * 9 * (FEA_I + FEA_F);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic [BW-1:0]   s_fea = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [BW-1:0]   m_fea;
    logic [SW_W-1:0] m_sw_id;
    logic            m_last;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [4:0]      level;
    logic [15:0]     stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    svm_feature_slice #(
        .FEA_I  (FEA_I),
        .FEA_F  (FEA_F),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .SW_W   (SW_W),
        .SW_NUM (SW_NUM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .s_fea     (s_fea),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_fea     (m_fea),
        .m_sw_id   (m_sw_id),
        .m_last    (m_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .level     (level),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mk(input int k);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'(k * 17 + 3);
        b = 8'(~(k * 29));
        return {9{a, b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] stall_exp(input int n);
`ifdef SVM_SLICE_STATS_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    initial begin
        // Reset state
        tick();
        chk("rst_s_ready", BW'(s_ready), BW'(1));
        chk("rst_m_valid", BW'(m_valid), BW'(0));
        chk("rst_level",   BW'(level),   BW'(0));
        chk("rst_m_last",  BW'(m_last),  BW'(0));
        chk("rst_m_sw_id", BW'(m_sw_id), BW'(0));
        chk("rst_m_fea",   m_fea,        BW'(0));
        chk("rst_stall",   BW'(stall_cnt), BW'(0));
        rst = 1'b1;
        tick();

        // Three bundles streamed with m_ready high: one-cycle latency, ids 0..2
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_fea = mk(i);
            tick();
            chk($sformatf("str_valid%0d", i), BW'(m_valid), BW'(1));
            chk($sformatf("str_fea%0d", i),   m_fea,        mk(i));
            chk($sformatf("str_id%0d", i),    BW'(m_sw_id), BW'(i));
            chk($sformatf("str_lvl%0d", i),   BW'(level),   BW'(1));
        end
        s_valid = 1'b0;
        tick();
        chk("drain_valid", BW'(m_valid), BW'(0));
        chk("drain_level", BW'(level),   BW'(0));

        // Backpressure: window counter is at 3, the final window of the frame
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_fea   = mk(3);
        tick();
        chk("bp_lvl1",  BW'(level),   BW'(1));
        chk("bp_id3",   BW'(m_sw_id), BW'(3));
        chk("bp_last3", BW'(m_last),  BW'(1));
        s_fea = mk(4);
        tick();
        chk("bp_lvl2",   BW'(level),   BW'(2));
        chk("bp_sready", BW'(s_ready), BW'(0));
        chk("bp_head",   m_fea,        mk(3));
        s_fea = mk(5);
        tick();
        tick();
        chk("bp_held_lvl",  BW'(level), BW'(2));
        chk("bp_held_head", m_fea,      mk(3));
        chk("bp_stall3",    BW'(stall_cnt), BW'(stall_exp(3)));

        // Full slice with simultaneous pop and push request: pop only
        m_ready = 1'b1;
        tick();
        chk("full_pop_lvl",    BW'(level),   BW'(1));
        chk("full_pop_sready", BW'(s_ready), BW'(1));
        chk("full_pop_head",   m_fea,        mk(4));
        chk("full_pop_id",     BW'(m_sw_id), BW'(0));
        chk("full_pop_last",   BW'(m_last),  BW'(0));
        m_ready = 1'b0;
        tick();
        chk("refill_lvl",   BW'(level),     BW'(2));
        chk("refill_stall", BW'(stall_cnt), BW'(stall_exp(4)));

        // Flush with a bundle offered: bundle dropped, counter cleared
        flush = 1'b1;
        s_fea = mk(6);
        tick();
        flush = 1'b0;
        chk("flush_lvl",    BW'(level),     BW'(0));
        chk("flush_valid",  BW'(m_valid),   BW'(0));
        chk("flush_sready", BW'(s_ready),   BW'(1));
        chk("flush_stall",  BW'(stall_cnt), BW'(stall_exp(5)));

        // Six bundles after flush: ids wrap 0,1,2,3,0,1 with last on the 4th
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_fea = mk(7 + i);
            tick();
            chk($sformatf("wrap_fea%0d", i),  m_fea,        mk(7 + i));
            chk($sformatf("wrap_id%0d", i),   BW'(m_sw_id), BW'(i % 4));
            chk($sformatf("wrap_last%0d", i), BW'(m_last),  BW'(i == 3));
        end
        s_valid = 1'b0;
        chk("pre_arst_lvl", BW'(level), BW'(1));

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid",  BW'(m_valid),   BW'(0));
        chk("arst_level",  BW'(level),     BW'(0));
        chk("arst_sready", BW'(s_ready),   BW'(1));
        chk("arst_stall",  BW'(stall_cnt), BW'(0));
        #1;
        rst = 1'b1;
        tick();
        s_valid = 1'b1;
        s_fea   = mk(20);
        tick();
        s_valid = 1'b0;
        chk("post_arst_id",  BW'(m_sw_id), BW'(0));
        chk("post_arst_fea", m_fea,        mk(20));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
